// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and memory.
interface instr_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-word skid buffer,
// redirect handling with late-response kill, and the IF/ID pipeline register.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       PC_EN_IF,
    input  logic                       reg_FD_EN,
    input  logic                       reg_FD_stall,
    input  logic                       reg_FD_flush,
    input  logic                       Branch_ID,
    input  logic [31:0]                PC_target_ID,
    instr_fetch_stage_if.master        imem,
    output logic [31:0]                PC_ID,
    output logic [31:0]                inst_ID,
    output logic                       valid_ID,
    output logic [31:0]                fetch_count
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic        kill_q, kill_d;
    logic        started_q, started_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic [31:0] cnt_q, cnt_d;

    logic        req;
    logic        accept;
    logic        issue;
    logic        resp;
    logic        word_avail;
    logic [31:0] word;
    logic        load;

    assign accept     = PC_EN_IF & reg_FD_EN & ~reg_FD_stall;
    assign issue      = req & imem.imem_ready;
    assign resp       = (state_q == S_WAIT) & imem.imem_rvalid;
    // A killed response belongs to a fetch made before the redirect; it never counts as a word.
    assign word_avail = (resp & ~kill_q) | (state_q == S_HOLD);
    assign word       = (state_q == S_HOLD) ? buf_q : imem.imem_rdata;
    assign load       = word_avail & accept & ~reg_FD_flush & ~Branch_ID;
    assign started_d  = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            kill_q    <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            started_q <= started_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            S_REQ: begin
                if (issue) begin
                    state_d = S_WAIT;
                    kill_d  = Branch_ID;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    kill_d  = 1'b0;
                    state_d = (Branch_ID | kill_q | load) ? S_REQ : S_HOLD;
                end else if (Branch_ID) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (Branch_ID | load) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        req            = started_q & (state_q == S_REQ);
        imem.imem_req  = req;
        imem.imem_addr = pc_q;
    end

    always_comb begin
        pc_d       = pc_q;
        buf_d      = buf_q;
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        cnt_d      = cnt_q;
        if (Branch_ID) begin
            pc_d = PC_target_ID & ~32'h3;
        end else if (load) begin
            pc_d = pc_q + 32'd4;
        end
        if (resp & ~kill_q & ~load) buf_d = imem.imem_rdata;
        if (load) begin
            pc_id_d    = pc_q;
            inst_id_d  = word;
            valid_id_d = 1'b1;
            cnt_d      = cnt_q + 32'd1;
        end else if (Branch_ID | reg_FD_flush | accept) begin
            inst_id_d  = NOP;
            valid_id_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_id_q    <= 32'h0;
            inst_id_q  <= NOP;
            valid_id_q <= 1'b0;
            cnt_q      <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
            cnt_q      <= cnt_d;
        end
    end

    // Buffer contents only matter while in HOLD, so the word itself needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign PC_ID       = pc_id_q;
    assign inst_ID     = inst_id_q;
    assign valid_ID    = valid_id_q;
    assign fetch_count = cnt_q;

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 PC_EN_IF  input  1  hazard unit fetch enable; 0 = hold PC and do not advance.
REQ-005 reg_FD_EN  input  1  IF/ID register enable.
REQ-006 reg_FD_stall  input  1  IF/ID register hold.
REQ-007 reg_FD_flush  input  1  IF/ID register bubble insert.
REQ-008 Branch_ID  input  1  redirect request from ID.
REQ-009 PC_target_ID  input  32  redirect target address.
REQ-010 imem_req  output  1  instruction memory request valid.
REQ-011 imem_addr  output  32  request address, word aligned.
REQ-012 imem_ready  input  1  memory accepts the request this cycle.
REQ-013 imem_rvalid  input  1  read data valid.
REQ-014 imem_rdata  input  32  read data.
REQ-015 PC_ID  output  32  IF/ID registered PC.
REQ-016 inst_ID  output  32  IF/ID registered instruction.
REQ-017 valid_ID  output  1  IF/ID holds a real instruction.
REQ-018 fetch_count  output  32  count of instructions delivered to IF/ID.
REQ-019 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address.
REQ-020 Parameter NOP, default 32'h0000_0013, is the bubble instruction.

Function
REQ-021 FSM states SHALL be REQ, WAIT and HOLD, with one outstanding request maximum.
REQ-022 "accept" SHALL mean PC_EN_IF & reg_FD_EN & ~reg_FD_stall.
REQ-023 REQ: imem_req=1 and imem_addr=PC; imem_ready=1 -> WAIT, otherwise stay in REQ with the address held stable.
REQ-024 WAIT: imem_rvalid=1 with accept -> load IF/ID {PC, imem_rdata, valid=1}, PC<=PC+4, go to REQ.
REQ-025 WAIT: imem_rvalid=1 without accept -> capture the word in a one-entry buffer, go to HOLD; PC is unchanged.
REQ-026 HOLD: imem_req=0; on accept -> load IF/ID from the buffer, PC<=PC+4, go to REQ.
REQ-027 On accept with no word available, IF/ID SHALL load a bubble {PC_ID unchanged, NOP, valid=0}.
REQ-028 When accept=0 and no flush, IF/ID SHALL hold all fields.
REQ-029 Branch_ID=1 has top priority, and all of the following SHALL happen in the same cycle:
- PC<=PC_target_ID with bits [1:0] forced to 0.
- IF/ID becomes a bubble.
- The HOLD buffer is discarded.
- The FSM goes to REQ.
REQ-030 A redirect in WAIT without rvalid SHALL set kill=1, stay in WAIT, and discard the next rvalid data; this takes the path WAIT -> REQ, with kill cleared and no IF/ID load.
REQ-031 A redirect in WAIT coinciding with rvalid SHALL discard the data with no kill needed.
REQ-032 A redirect in REQ coinciding with imem_ready SHALL go to WAIT with kill=1.
REQ-033 reg_FD_flush=1 without Branch_ID SHALL bubble IF/ID only; PC, FSM and buffer are unaffected.
REQ-034 A word delivered that cycle SHALL be retained in the buffer (go to HOLD).
REQ-035 PC arithmetic SHALL be 32-bit modulo, so 32'hFFFF_FFFC+4 = 0.
REQ-036 fetch_count SHALL increment by 1 on every valid=1 load of IF/ID and wrap at 2^32.
REQ-037 Fetch latency SHALL be: address presented in cycle N, IF/ID valid in the cycle after rvalid.

Reset
REQ-038 rst_n=0 SHALL asynchronously set all of the following:
- PC=RESET_PC and FSM=REQ.
- kill=0 and buffer empty.
- PC_ID=0, inst_ID=NOP and valid_ID=0.
- fetch_count=0.
REQ-039 During reset, imem_req SHALL be 0; it SHALL be 1 from the first clock edge after rst_n rises.
REQ-040 If reset is asserted mid-request, the returning rvalid after release SHALL be ignored unless the FSM is in WAIT.

Verification
REQ-041 Zero-wait memory (ready=1, rvalid 1 cycle later) with accept held at 1 -> PC_ID sequence 0,4,8 and valid_ID=1 every second cycle; fetch_count=3 after three loads.
REQ-042 reg_FD_stall=1 during rvalid (data 32'h00A00093) -> FSM HOLD, imem_req=0; stall released -> inst_ID=32'h00A00093, PC advances by 4.
REQ-043 Branch_ID=1 with PC_target_ID=32'h0000_0103 while in WAIT -> next rvalid data dropped; next imem_addr=32'h0000_0100; IF/ID shows NOP with valid=0.
REQ-044 imem_ready held 0 for 5 cycles -> imem_addr stable and IF/ID bubbles inserted on accept.
REQ-045 Redirect to 32'hFFFF_FFFC, then two fetches -> second imem_addr=32'h0000_0000.
REQ-046 rst_n pulsed low mid-WAIT -> all outputs reach reset values immediately; first request after release goes to RESET_PC.
